// File: rtl/addsub_accum_ctrl_if.sv
// Request/response channel bundle for the add/sub accumulator controller.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1; the sender holds its payload stable while
// valid is high and ready is low.
interface addsub_accum_ctrl_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [WIDTH-1:0] in_operand;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_acc;
   logic             out_carry;
   logic             out_zero;
   logic             out_borrow;
   logic [CNT_W-1:0] out_evt_cnt;

   // Requester / response consumer side
   modport master (
      output in_valid, in_op, in_operand, out_ready,
      input  in_ready, out_valid, out_acc, out_carry, out_zero, out_borrow, out_evt_cnt
   );

   // Controller side
   modport slave (
      input  in_valid, in_op, in_operand, out_ready,
      output in_ready, out_valid, out_acc, out_carry, out_zero, out_borrow, out_evt_cnt
   );
endinterface

// File: rtl/addsub_accum_ctrl.sv
// Sequential controller + accumulator sitting in front of an external
// WIDTH-bit adder_subtractor. One op in flight: IDLE accepts, EXEC lets the
// adder settle on registered inputs and writes back, RESP presents the result.
module addsub_accum_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   addsub_accum_ctrl_if.slave bus,
   output logic [WIDTH-1:0] addsub_a,
   output logic [WIDTH-1:0] addsub_b,
   output logic             addsub_sub,
   input  logic [WIDTH-1:0] addsub_result,
   input  logic             addsub_carry,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [1:0]       op_q, op_d;
   logic             carry_q, carry_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             evt;

   // State and datapath registers; reset abandons any op in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         operand_q <= '0;
         op_q      <= OP_ADD;
         carry_q   <= 1'b0;
         borrow_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         operand_q <= operand_d;
         op_q      <= op_d;
         carry_q   <= carry_d;
         borrow_q  <= borrow_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state and write-back logic; everything holds unless the state says otherwise
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      operand_d = operand_q;
      op_d      = op_q;
      carry_d   = carry_q;
      borrow_d  = borrow_q;
      cnt_d     = cnt_q;
      // Overflow on ADD or underflow (no carry out) on SUB
      evt       = ((op_q == OP_ADD) && addsub_carry) || ((op_q == OP_SUB) && !addsub_carry);
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d      = bus.in_op;
               operand_d = bus.in_operand;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
            case (op_q)
               OP_ADD, OP_SUB: begin
                  acc_d    = addsub_result;
                  carry_d  = addsub_carry;
                  borrow_d = (op_q == OP_SUB) && !addsub_carry;
                  if (evt && (cnt_q != {CNT_W{1'b1}})) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               OP_LOAD: begin
                  acc_d    = operand_q;
                  carry_d  = 1'b0;
                  borrow_d = 1'b0;
               end
               default: begin
                  acc_d    = '0;
                  carry_d  = 1'b0;
                  borrow_d = 1'b0;
                  cnt_d    = '0;
               end
            endcase
         end
         RESP: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == RESP);
   assign bus.out_acc     = acc_q;
   assign bus.out_carry   = carry_q;
   assign bus.out_borrow  = borrow_q;
   assign bus.out_zero    = (acc_q == '0);
   assign bus.out_evt_cnt = cnt_q;

   assign addsub_a   = acc_q;
   assign addsub_b   = operand_q;
   assign addsub_sub = (op_q == OP_SUB);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_addsub_accum_ctrl.sv
// Directed bench for addsub_accum_ctrl with a behavioural 4-bit adder_subtractor.
module tb_addsub_accum_ctrl;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] addsub_a, addsub_b, addsub_result;
   logic       addsub_sub, addsub_carry;
   logic [1:0] state_dbg;
   logic [4:0] sum5;
   int         tests_run = 0;
   int         tests_failed = 0;

   addsub_accum_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();

   addsub_accum_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .addsub_a      (addsub_a),
      .addsub_b      (addsub_b),
      .addsub_sub    (addsub_sub),
      .addsub_result (addsub_result),
      .addsub_carry  (addsub_carry),
      .state_dbg     (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // External adder_subtractor: a + b, or a + ~b + 1 with carry = no borrow
   always_comb begin
      if (addsub_sub) sum5 = {1'b0, addsub_a} + {1'b0, ~addsub_b} + 5'd1;
      else            sum5 = {1'b0, addsub_a} + {1'b0, addsub_b};
   end
   assign addsub_result = sum5[3:0];
   assign addsub_carry  = sum5[4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One full op; called at posedge+1. hold = RESP cycles with out_ready low.
   task automatic run_op(input logic [1:0] op, input logic [3:0] opnd,
                         input logic [3:0] e_acc, input logic e_c, input logic e_b,
                         input logic [7:0] e_cnt, input int hold);
      int n = 0;
      while (!bus.in_ready && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_wait", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid   = 1'b1;
      bus.in_op      = op;
      bus.in_operand = opnd;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("exec_state", {30'd0, state_dbg}, 32'd1);
      check("exec_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("exec_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("exec_sub", {31'd0, addsub_sub}, {31'd0, op == OP_SUB});
      check("exec_b", {28'd0, addsub_b}, {28'd0, opnd});
      @(posedge clk); #1;
      check("resp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("resp_acc", {28'd0, bus.out_acc}, {28'd0, e_acc});
      check("resp_carry", {31'd0, bus.out_carry}, {31'd0, e_c});
      check("resp_borrow", {31'd0, bus.out_borrow}, {31'd0, e_b});
      check("resp_zero", {31'd0, bus.out_zero}, {31'd0, e_acc == 4'd0});
      check("resp_cnt", {24'd0, bus.out_evt_cnt}, {24'd0, e_cnt});
      for (int i = 0; i < hold; i++) begin
         bus.out_ready  = 1'b0;
         bus.in_valid   = (i % 2 == 0);
         bus.in_op      = OP_CLEAR;
         bus.in_operand = 4'hf;
         @(posedge clk); #1;
         check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("hold_acc", {28'd0, bus.out_acc}, {28'd0, e_acc});
         check("hold_cnt", {24'd0, bus.out_evt_cnt}, {24'd0, e_cnt});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("exit_idle", {30'd0, state_dbg}, 32'd0);
      check("exit_addsub_a", {28'd0, addsub_a}, {28'd0, e_acc});
   endtask

   // Main sequence
   initial begin
      logic [3:0] m_acc;
      logic [7:0] m_cnt;
      logic [4:0] s;
      bus.in_valid   = 1'b0;
      bus.in_op      = OP_ADD;
      bus.in_operand = 4'd0;
      bus.out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // Reset values
      check("rst_state", {30'd0, state_dbg}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_zero", {31'd0, bus.out_zero}, 32'd1);
      check("rst_a", {28'd0, addsub_a}, 32'd0);
      check("rst_b", {28'd0, addsub_b}, 32'd0);
      check("rst_sub", {31'd0, addsub_sub}, 32'd0);
      check("rst_cnt", {24'd0, bus.out_evt_cnt}, 32'd0);
      // No capture while reset is held
      bus.in_valid   = 1'b1;
      bus.in_op      = OP_LOAD;
      bus.in_operand = 4'd7;
      @(posedge clk); #1;
      check("rst_no_capture", {30'd0, state_dbg}, 32'd0);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic ops (hand-computed)
      run_op(OP_LOAD, 4'd5, 4'd5,  1'b0, 1'b0, 8'd0, 0);
      run_op(OP_ADD,  4'd3, 4'd8,  1'b0, 1'b0, 8'd0, 0);
      run_op(OP_ADD,  4'd8, 4'd0,  1'b1, 1'b0, 8'd1, 0);
      run_op(OP_LOAD, 4'd3, 4'd3,  1'b0, 1'b0, 8'd1, 0);
      run_op(OP_SUB,  4'd8, 4'hb,  1'b0, 1'b1, 8'd2, 0);
      run_op(OP_LOAD, 4'd8, 4'd8,  1'b0, 1'b0, 8'd2, 0);
      run_op(OP_SUB,  4'd3, 4'd5,  1'b1, 1'b0, 8'd2, 0);
      // Backpressure: 5 held RESP cycles with in_valid pulsing CLEAR
      run_op(OP_ADD,  4'd2, 4'd7,  1'b0, 1'b0, 8'd2, 5);

      // Asynchronous reset in the middle of EXEC
      bus.in_valid   = 1'b1;
      bus.in_op      = OP_LOAD;
      bus.in_operand = 4'd9;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("mid_exec_state", {30'd0, state_dbg}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_state", {30'd0, state_dbg}, 32'd0);
      check("arst_a", {28'd0, addsub_a}, 32'd0);
      check("arst_b", {28'd0, addsub_b}, 32'd0);
      check("arst_zero", {31'd0, bus.out_zero}, 32'd1);
      check("arst_cnt", {24'd0, bus.out_evt_cnt}, 32'd0);
      check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
      check("arst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("arst_after_valid", {31'd0, bus.out_valid}, 32'd0);
      run_op(OP_ADD, 4'd6, 4'd6, 1'b0, 1'b0, 8'd0, 0);

      // Counter saturation: repeated ADD 15 from acc=15
      run_op(OP_LOAD, 4'hf, 4'hf, 1'b0, 1'b0, 8'd0, 0);
      m_acc = 4'hf;
      m_cnt = 8'd0;
      for (int i = 0; i < 300; i++) begin
         s     = {1'b0, m_acc} + 5'd15;
         m_acc = s[3:0];
         if (s[4] && m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
         run_op(OP_ADD, 4'hf, m_acc, s[4], 1'b0, m_cnt, 0);
      end
      check("sat_cnt", {24'd0, bus.out_evt_cnt}, 32'd255);
      run_op(OP_CLEAR, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 0);
      check("clear_zero", {31'd0, bus.out_zero}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog run did not complete");
      $fatal(1, "timeout");
   end

endmodule
